ce_period_meter: RTL and testbench

CE_PERIOD_METER -- requirements
Module: ce_period_meter

---
 rtl/ce_period_meter.sv | 135 +++++++++++++
 tb/tb_ce_period_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_period_meter.sv
// Clock-enable period meter: measures strobe spacing, tracks lock and timeout.
// Optional CE_METER_STATS_EN adds a saturating mismatch counter on err_count.
module ce_period_meter #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 0
) (
    input  logic             clk32M768,
    input  logic             rst,
    input  logic             ce_in,
    input  logic [CNT_W-1:0] expected_period,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             timeout,
    output logic [15:0]      err_count
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);
    localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } state_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0] mcnt, mcnt_nxt;
    logic [CNT_W:0]  diff;
    logic            sat;
    logic            match;
    logic            eval;
    logic            err_nxt;
    logic            to_nxt;
    logic            valid_nxt;

    assign sat    = (cnt == {CNT_W{1'b1}});
    assign eval   = ce_in && (state != IDLE);
    assign locked = (state == LOCKED);

    always_comb begin
        if (cnt >= expected_period)
            diff = {1'b0, cnt} - {1'b0, expected_period};
        else
            diff = {1'b0, expected_period} - {1'b0, cnt};
    end

    // A zero nominal period can never be matched.
    assign match = (expected_period != '0) && (diff <= TOL_V);

    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        err_nxt   = 1'b0;
        valid_nxt = 1'b0;
        to_nxt    = timeout;
        if (ce_in) begin
            to_nxt = 1'b0;
            unique case (state)
                IDLE: begin
                    state_nxt = TRACK;
                    mcnt_nxt  = '0;
                end
                TRACK: begin
                    valid_nxt = 1'b1;
                    if (!match) begin
                        mcnt_nxt = '0;
                    end else if ((mcnt + 1'b1) == LOCK_V) begin
                        mcnt_nxt  = LOCK_V;
                        state_nxt = LOCKED;
                    end else begin
                        mcnt_nxt = mcnt + 1'b1;
                    end
                end
                LOCKED: begin
                    valid_nxt = 1'b1;
                    if (!match) begin
                        err_nxt   = 1'b1;
                        mcnt_nxt  = '0;
                        state_nxt = TRACK;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                end
            endcase
        end else if (sat && (state != IDLE)) begin
            // Strobe lost: drop lock and wait for a fresh first strobe.
            to_nxt    = 1'b1;
            state_nxt = IDLE;
            mcnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk32M768) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mcnt         <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            err_pulse    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            mcnt         <= mcnt_nxt;
            period_valid <= valid_nxt;
            err_pulse    <= err_nxt;
            timeout      <= to_nxt;
            if (eval)
                period_out <= cnt;
            if (ce_in)
                cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (!sat)
                cnt <= cnt + 1'b1;
        end
    end

`ifdef CE_METER_STATS_EN
    always_ff @(posedge clk32M768) begin
        if (rst)
            err_count <= '0;
        else if (err_nxt && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ce_period_meter.sv
// Self-checking bench for ce_period_meter: vector table, directed corners,
// and randomized strobes checked against an event-level reference model.
module tb_ce_period_meter;

    logic        clk32M768 = 1'b0;
    logic        rst       = 1'b1;
    logic        ce_in     = 1'b0;
    logic [15:0] cur_exp   = 16'd16;

    logic [15:0] po0, ec0, po1, ec1, ec2;
    logic        pv0, lk0, ep0, to0;
    logic        pv1, lk1, ep1, to1;
    logic [3:0]  po2;
    logic        pv2, lk2, ep2, to2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk32M768 = ~clk32M768;

    ce_period_meter #(.CNT_W(16), .LOCK_CNT(4), .TOL(0)) dut0 (
        .clk32M768(clk32M768), .rst(rst), .ce_in(ce_in),
        .expected_period(cur_exp), .period_out(po0),
        .period_valid(pv0), .locked(lk0), .err_pulse(ep0),
        .timeout(to0), .err_count(ec0)
    );

    ce_period_meter #(.CNT_W(16), .LOCK_CNT(4), .TOL(1)) dut1 (
        .clk32M768(clk32M768), .rst(rst), .ce_in(ce_in),
        .expected_period(cur_exp), .period_out(po1),
        .period_valid(pv1), .locked(lk1), .err_pulse(ep1),
        .timeout(to1), .err_count(ec1)
    );

    ce_period_meter #(.CNT_W(4), .LOCK_CNT(4), .TOL(0)) dut2 (
        .clk32M768(clk32M768), .rst(rst), .ce_in(ce_in),
        .expected_period(cur_exp[3:0]), .period_out(po2),
        .period_valid(pv2), .locked(lk2), .err_pulse(ep2),
        .timeout(to2), .err_count(ec2)
    );

    // Reference model for dut0, expressed in absolute strobe times.
    longint m_t = 0;
    longint m_last = 0;
    bit     m_track = 0;
    int     m_matches = 0;
    bit     m_locked = 0;
    bit     m_valid = 0;
    bit     m_err = 0;
    bit     m_to = 0;
    longint m_pout = 0;
    int     m_errcnt = 0;

    function automatic void model_step(input bit c, input bit r, input longint e);
        longint p;
        longint d;
        m_t++;
        m_valid = 0;
        m_err   = 0;
        if (r) begin
            m_track = 0; m_matches = 0; m_locked = 0;
            m_to = 0; m_pout = 0; m_errcnt = 0;
            return;
        end
        if (c) begin
            if (m_track) begin
                p = m_t - m_last;
                d = (p > e) ? p - e : e - p;
                m_pout  = p;
                m_valid = 1;
                if (e != 0 && d == 0) begin
                    if (!m_locked) begin
                        m_matches++;
                        if (m_matches >= 4) m_locked = 1;
                    end
                end else begin
                    if (m_locked) begin
                        m_err = 1;
`ifdef CE_METER_STATS_EN
                        if (m_errcnt < 65535) m_errcnt++;
`endif
                    end
                    m_locked  = 0;
                    m_matches = 0;
                end
            end else begin
                m_track   = 1;
                m_matches = 0;
            end
            m_to   = 0;
            m_last = m_t;
        end else if (m_track && (m_t - m_last) >= 65535) begin
            m_to = 1; m_locked = 0; m_track = 0; m_matches = 0;
        end
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input bit c, input bit r);
        ce_in = c;
        rst   = r;
        @(posedge clk32M768);
        model_step(c, r, longint'(cur_exp));
        #1;
        chk("model", {pv0, po0, lk0, ep0, to0, ec0},
            {m_valid, m_pout[15:0], m_locked, m_err, m_to, m_errcnt[15:0]});
    endtask

    task automatic do_strobe(input int gap);
        for (int i = 1; i < gap; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    typedef struct {
        bit          ce;
        logic [15:0] ep;
        bit          v;
        logic [15:0] po;
        bit          lk;
        bit          er;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int  n;
        bit  hit;
        tbl[0] = '{1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 0};
        tbl[2] = '{1, 1, 1, 1, 0, 0};
        tbl[3] = '{1, 1, 1, 1, 0, 0};
        tbl[4] = '{1, 1, 1, 1, 1, 0};
        tbl[5] = '{0, 1, 0, 1, 1, 0};
        tbl[6] = '{0, 0, 0, 1, 1, 0};
        tbl[7] = '{1, 0, 1, 3, 0, 1};
        tbl[8] = '{0, 0, 0, 3, 0, 0};
        tbl[9] = '{1, 2, 1, 2, 0, 0};

        do_reset();
        chk("reset_state", {pv0, po0, lk0, ep0, to0, ec0}, 0);
        for (int i = 0; i < 10; i++) begin
            cur_exp = tbl[i].ep;
            step(tbl[i].ce, 1'b0);
            chk($sformatf("vec%0d", i), {pv0, po0, lk0, ep0},
                {tbl[i].v, tbl[i].po, tbl[i].lk, tbl[i].er});
        end

        // Nominal lock on the fifth strobe.
        cur_exp = 16;
        do_reset();
        step(1'b1, 1'b0);
        chk("first_no_valid", pv0, 0);
        for (int k = 1; k <= 4; k++) begin
            do_strobe(16);
            chk("lock_valid", {pv0, po0}, {1'b1, 16'd16});
            chk("lock_level", lk0, (k == 4));
        end

        // One late strobe: TOL 0 drops lock, TOL 1 holds it.
        do_strobe(17);
        chk("late_err_tol0", {ep0, lk0, po0}, {1'b1, 1'b0, 16'd17});
        chk("late_tol1", {ep1, lk1}, 2'b01);
        do_strobe(15);
        chk("early_tol0", {ep0, lk0}, 2'b00);
        chk("early_tol1", {ep1, lk1}, 2'b01);
        for (int k = 1; k <= 4; k++) begin
            do_strobe(16);
            chk("relock", lk0, (k == 4));
        end
        chk("tol1_steady", lk1, 1);

        // Three mismatches while locked, then reset coincident with a strobe.
        for (int k = 0; k < 3; k++) begin
            do_strobe(18);
            for (int j = 0; j < 4; j++) do_strobe(16);
        end
`ifdef CE_METER_STATS_EN
        chk("errcnt_before_rst", ec0, 4);
`else
        chk("errcnt_before_rst", ec0, 0);
`endif
        chk("locked_before_rst", lk0, 1);
        step(1'b1, 1'b1);
        chk("rst_outputs", {pv0, po0, lk0, ep0, to0, ec0}, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("post_rst_first", pv0, 0);
        do_strobe(16);
        chk("post_rst_second", {pv0, po0}, {1'b1, 16'd16});

        // Small counter: saturation coinciding with a strobe, then timeout.
        step(1'b1, 1'b0);
        do_strobe(15);
        chk("sat_ce_prio", {pv2, po2, to2}, {1'b1, 4'd15, 1'b0});
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0);
            if (i == 14) chk("to_before_sat", to2, 0);
        end
        chk("to_small", {to2, lk2}, 2'b10);

        // Lock, stop strobes, wait for timeout on the 16-bit meter.
        for (int k = 0; k < 5; k++) do_strobe(16);
        chk("lock_before_to", lk0, 1);
        n = 0;
        hit = 0;
        while (n < 70000 && !hit) begin
            step(1'b0, 1'b0);
            n++;
            hit = to0;
        end
        chk("to_cycles", n, 65535);
        chk("to_unlock", {to0, lk0}, 2'b10);
        step(1'b1, 1'b0);
        chk("to_clear_novalid", {to0, pv0}, 2'b00);
        do_strobe(16);
        chk("to_then_valid", pv0, 1);

        // Randomized strobes with occasional jitter, nominal changes and resets.
        for (int s = 0; s < 400; s++) begin
            int g;
            if ($urandom_range(0, 29) == 0)
                cur_exp = 16'($urandom_range(0, 7));
            g = int'(cur_exp);
            if (g == 0) g = 3;
            if ($urandom_range(0, 7) == 0)
                g = g + int'($urandom_range(0, 2)) - 1;
            if (g < 1) g = 1;
            if ($urandom_range(0, 99) == 0)
                step(1'b0, 1'b1);
            do_strobe(g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
